pipeline_arbiter: RTL and testbench



---
 rtl/pipeline_arbiter.sv | 153 +++++++++++++++
 tb/tb_pipeline_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_arbiter.sv
// pipeline_arbiter: round-robin front end for a shared three-stage arithmetic
// pipeline. It picks one requester per cycle and drives that requester's
// operands into the datapath. A latency-matched tag pipe records which
// requester owns each in-flight result. When a tag leaves the pipe, the result
// is returned to its owner as a registered one-cycle response.
module pipeline_arbiter #(
  parameter int N    = 10,
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*N-1:0] req_c,
  input  logic [NREQ*N-1:0] req_d,
  output logic [N-1:0]      dp_a,
  output logic [N-1:0]      dp_b,
  output logic [N-1:0]      dp_c,
  output logic [N-1:0]      dp_d,
  input  logic [N-1:0]      dp_f,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_data,
  output logic              idle
);

  localparam int              IW          = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0]   LAST_IDX    = IW'(NREQ - 1);
  localparam logic [IW-1:0]   IDX_ONE     = IW'(1'b1);
  localparam logic [NREQ-1:0] ONE_HOT_LSB = {{(NREQ-1){1'b0}}, 1'b1};

  // Architectural state
  logic [IW-1:0]   ptr_r;
  logic [NREQ-1:0] busy_r;
  logic [LAT-1:0]  tag_vld_r;
  logic [IW-1:0]   tag_idx_r [LAT];
  logic [NREQ-1:0] rsp_valid_r;
  logic [N-1:0]    rsp_data_r;

  // Combinational decisions
  logic [NREQ-1:0] eligible_s;
  logic            grant_vld_s;
  logic [IW-1:0]   grant_idx_s;
  logic            issue_out_s;
  logic [IW-1:0]   ptr_nxt_s;
  logic [NREQ-1:0] busy_set_s;
  logic [NREQ-1:0] busy_clr_s;
  logic [NREQ-1:0] busy_nxt_s;
  logic            rsp_fire_s;
  logic [IW-1:0]   rsp_idx_s;

  // A requester with an operation in flight is never eligible.
  assign eligible_s = req_valid & ~busy_r;

  // Round-robin search: the first eligible index at or after ptr, with wrap.
  always_comb begin
    logic [IW-1:0] cand;
    logic          hit;
    grant_vld_s = 1'b0;
    grant_idx_s = {IW{1'b0}};
    cand        = ptr_r;
    hit         = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      hit         = ~grant_vld_s & eligible_s[cand];
      grant_idx_s = hit ? cand : grant_idx_s;
      grant_vld_s = grant_vld_s | hit;
      cand        = (cand == LAST_IDX) ? {IW{1'b0}} : cand + IDX_ONE;
    end
  end

  // The outward grant is suppressed while reset is asserted. Internal state is
  // held in reset anyway, so only the ports need this gating.
  assign issue_out_s = grant_vld_s & rst_n;
  assign req_ready   = issue_out_s ? (ONE_HOT_LSB << grant_idx_s) : {NREQ{1'b0}};

  // Steer the granted requester's operands into the datapath; zero when idle.
  always_comb begin
    if (issue_out_s) begin
      dp_a = req_a[grant_idx_s*N +: N];
      dp_b = req_b[grant_idx_s*N +: N];
      dp_c = req_c[grant_idx_s*N +: N];
      dp_d = req_d[grant_idx_s*N +: N];
    end else begin
      dp_a = {N{1'b0}};
      dp_b = {N{1'b0}};
      dp_c = {N{1'b0}};
      dp_d = {N{1'b0}};
    end
  end

  // Next pointer and busy flags. Set and clear never target the same index,
  // because the index being cleared is still busy and cannot be granted.
  always_comb begin
    rsp_fire_s = tag_vld_r[LAT-1];
    rsp_idx_s  = tag_idx_r[LAT-1];
    busy_set_s = grant_vld_s ? (ONE_HOT_LSB << grant_idx_s) : {NREQ{1'b0}};
    busy_clr_s = rsp_fire_s  ? (ONE_HOT_LSB << rsp_idx_s)   : {NREQ{1'b0}};
    busy_nxt_s = (busy_r & ~busy_clr_s) | busy_set_s;
    if (grant_vld_s) begin
      ptr_nxt_s = (grant_idx_s == LAST_IDX) ? {IW{1'b0}} : grant_idx_s + IDX_ONE;
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Round-robin pointer and per-requester in-flight flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r  <= {IW{1'b0}};
      busy_r <= {NREQ{1'b0}};
    end else begin
      ptr_r  <= ptr_nxt_s;
      busy_r <= busy_nxt_s;
    end
  end

  // Tag pipe: shifts every edge so that its tail lines up with dp_f.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_r <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        tag_idx_r[i] <= {IW{1'b0}};
      end
    end else begin
      tag_vld_r[0] <= grant_vld_s;
      tag_idx_r[0] <= grant_idx_s;
      for (int i = 1; i < LAT; i++) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_idx_r[i] <= tag_idx_r[i-1];
      end
    end
  end

  // Registered response: one-hot strobe to the owner; data holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= {NREQ{1'b0}};
      rsp_data_r  <= {N{1'b0}};
    end else if (rsp_fire_s) begin
      rsp_valid_r <= ONE_HOT_LSB << rsp_idx_s;
      rsp_data_r  <= dp_f;
    end else begin
      rsp_valid_r <= {NREQ{1'b0}};
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign idle      = ~(|busy_r) & ~(|tag_vld_r);

endmodule

// File: tb/tb_pipeline_arbiter.sv
// Testbench for pipeline_arbiter. It contains a behavioural three-stage
// F = ((A+B)+(C-D))*D datapath. It applies a table of single operations and
// then hand-written sequences for reset, rotation, wrap/skip and reset
// mid-flight.
module tb_pipeline_arbiter;
  localparam int N    = 10;
  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
  logic [N-1:0]      dp_a, dp_b, dp_c, dp_d;
  logic [N-1:0]      dp_f;
  logic [NREQ-1:0]   rsp_valid;
  logic [N-1:0]      rsp_data;
  logic              idle;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipeline_arbiter #(.N(N), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
    .dp_f(dp_f),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .idle(idle)
  );

  // Behavioural datapath: operands captured at edge E, F valid after E+2.
  logic [N-1:0] s1_ab = '0, s1_cd = '0, s1_d = '0, s2_sum = '0, s2_d = '0, s3_f = '0;
  always @(posedge clk) begin
    s1_ab  <= dp_a + dp_b;
    s1_cd  <= dp_c - dp_d;
    s1_d   <= dp_d;
    s2_sum <= s1_ab + s1_cd;
    s2_d   <= s1_d;
    s3_f   <= N'(s2_sum * s2_d);
  end
  assign dp_f = s3_f;

  typedef struct {
    int           idx;
    logic [N-1:0] a, b, c, d;
    logic [N-1:0] f;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [NREQ-1:0] oh(input int k);
    logic [NREQ-1:0] r;
    r = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ops(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] c, input logic [N-1:0] d);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_c[i*N +: N] = c;
    req_d[i*N +: N] = d;
  endtask

  initial begin
    vecs[0] = '{idx: 0, a: 10'd10,   b: 10'd20,  c: 10'd30, d: 10'd40, f: 10'd800};
    vecs[1] = '{idx: 1, a: 10'd0,    b: 10'd0,   c: 10'd0,  d: 10'd1,  f: 10'd1023};
    vecs[2] = '{idx: 2, a: 10'd3,    b: 10'd4,   c: 10'd10, d: 10'd2,  f: 10'd30};
    vecs[3] = '{idx: 3, a: 10'd100,  b: 10'd200, c: 10'd50, d: 10'd7,  f: 10'd353};
    vecs[4] = '{idx: 0, a: 10'd500,  b: 10'd500, c: 10'd0,  d: 10'd2,  f: 10'd972};
    vecs[5] = '{idx: 3, a: 10'd1023, b: 10'd1,   c: 10'd0,  d: 10'd0,  f: 10'd0};

    // Reset with every requester asking.
    rst_n = 1'b0;
    req_valid = '1;
    step();
    step();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_idle", idle, 1);
    rst_n = 1'b1;
    #1;
    chk("first_grant", req_ready, 4'b0001);
    req_valid = '0;
    step();

    // Table of single operations, each held valid until its busy clears.
    for (int v = 0; v < 6; v++) begin
      set_ops(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d);
      req_valid = oh(vecs[v].idx);
      #1;
      chk("vec_grant", req_ready, oh(vecs[v].idx));
      chk("vec_dp_a", dp_a, vecs[v].a);
      chk("vec_dp_d", dp_d, vecs[v].d);
      step();                                   // E
      chk("vec_busy_ready", req_ready, 0);
      chk("vec_busy_dp", dp_a, 0);
      chk("vec_not_idle", idle, 0);
      step();                                   // E+1
      chk("vec_busy_ready2", req_ready, 0);
      chk("vec_early_rsp1", rsp_valid, 0);
      step();                                   // E+2
      chk("vec_early_rsp2", rsp_valid, 0);
      chk("vec_busy_ready3", req_ready, 0);
      step();                                   // E+3
      chk("vec_rsp_valid", rsp_valid, oh(vecs[v].idx));
      chk("vec_rsp_data", rsp_data, vecs[v].f);
      chk("vec_regrant", req_ready, oh(vecs[v].idx));
      req_valid = '0;
      step();                                   // E+4
      chk("vec_rsp_off", rsp_valid, 0);
      chk("vec_rsp_hold", rsp_data, vecs[v].f);
      chk("vec_idle", idle, 1);
    end

    // Rotation from ptr=0 with everyone valid.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_ops(i, 10'd5, 10'd10, 10'd20, 10'd15);
    req_valid = '1;
    #1;
    chk("rot_grant0", req_ready, 4'b0001);
    for (int n = 0; n < 8; n++) begin
      step();
      chk("rot_grant", req_ready, oh((n + 1) % NREQ));
      if (n >= 3) begin
        chk("rot_rsp_valid", rsp_valid, oh((n - 3) % NREQ));
        chk("rot_rsp_data", rsp_data, 10'd300);
      end else begin
        chk("rot_rsp_none", rsp_valid, 0);
      end
    end
    req_valid = '0;
    for (int n = 0; n < 6; n++) step();
    chk("rot_idle", idle, 1);

    // Move ptr to 3 with a lone op on requester 2, then wrap and skip.
    req_valid = 4'b0100;
    #1;
    chk("ws_pre_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    for (int n = 0; n < 4; n++) step();
    req_valid = 4'b1010;
    #1;
    chk("ws_grant3", req_ready, 4'b1000);
    step();
    chk("ws_grant1", req_ready, 4'b0010);
    step();
    req_valid = '0;
    for (int n = 0; n < 5; n++) step();
    chk("ws_idle", idle, 1);
    req_valid = '1;
    #1;
    chk("ws_ptr2", req_ready, 4'b0100);
    req_valid = '0;
    step();

    // Reset one cycle after issue: the in-flight op must vanish.
    set_ops(0, 10'd10, 10'd20, 10'd30, 10'd40);
    req_valid = 4'b0001;
    #1;
    chk("mf_grant", req_ready, 4'b0001);
    step();                                     // E
    req_valid = '0;
    step();                                     // E+1
    rst_n = 1'b0;
    #1;
    chk("mf_rst_idle", idle, 1);
    chk("mf_rst_rsp", rsp_valid, 0);
    step();                                     // E+2
    rst_n = 1'b1;
    req_valid = 4'b0001;
    #1;
    chk("mf_regrant", req_ready, 4'b0001);
    req_valid = '0;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("mf_no_rsp", rsp_valid, 0);
    end
    chk("mf_idle", idle, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Safety net in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
